// File: rtl/fft_frame_sched_if.sv
// Sample-stream, FFT-core and status signals of the FFT input frame scheduler.
// slave = scheduler side, master = source/core side.
interface fft_frame_sched_if #(
    parameter int N_LOG2 = 3,
    parameter int DW     = 16
);
    logic              req_i;
    logic [DW-1:0]     data_i;
    logic              ready_o;
    logic              fft_start_o;
    logic              fft_bank_o;
    logic [N_LOG2-1:0] fft_rd_addr_i;
    logic [DW-1:0]     fft_rd_data_o;
    logic              fft_done_i;
    logic              overflow_o;
    logic [7:0]        frame_cnt_o;

    modport slave (
        input  req_i, data_i, fft_rd_addr_i, fft_done_i,
        output ready_o, fft_start_o, fft_bank_o, fft_rd_data_o, overflow_o, frame_cnt_o
    );

    modport master (
        output req_i, data_i, fft_rd_addr_i, fft_done_i,
        input  ready_o, fft_start_o, fft_bank_o, fft_rd_data_o, overflow_o, frame_cnt_o
    );
endinterface

// File: rtl/fft_frame_sched.sv
// Ping-pong input frame scheduler for the FFT core: fills one bank while the core reads the other.
// Define FFT_SCHED_BITREV_EN to store samples at bit-reversed addresses (DIT natural-order output).
module fft_frame_sched #(
    parameter int N_LOG2 = 3,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    fft_frame_sched_if.slave  bus
);
    localparam int N = 1 << N_LOG2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic              r_wr_bank;
    logic [N_LOG2-1:0] r_wr_cnt;
    logic [1:0]        r_full;
    logic              r_rd_bank;
    logic [1:0]        r_state;
    logic              r_overflow;
    logic [7:0]        r_frame_cnt;
    logic [DW-1:0]     r_rd_data;
    logic [DW-1:0]     r_mem [0:2*N-1];

    logic              w_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_done;
    logic [1:0]        w_set_full;
    logic [1:0]        w_clr_full;
    logic [N_LOG2-1:0] w_waddr;

    assign w_ready    = !r_full[r_wr_bank];
    assign w_accept   = bus.req_i && w_ready;
    assign w_last     = w_accept && (&r_wr_cnt);
    assign w_done     = (r_state == S_RUN) && bus.fft_done_i;
    // A completing write and a done never hit the same bank: the writer only targets non-full banks.
    assign w_set_full = w_last ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr_full = w_done ? (2'b01 << r_rd_bank) : 2'b00;

`ifdef FFT_SCHED_BITREV_EN
    always_comb begin
        w_waddr = '0;
        for (int unsigned i = 0; i < N_LOG2; i++) begin
            w_waddr[i] = r_wr_cnt[N_LOG2-1-i];
        end
    end
`else
    assign w_waddr = r_wr_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank  <= 1'b0;
            r_wr_cnt   <= '0;
            r_full     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_full <= (r_full | w_set_full) & ~w_clr_full;
            if (w_accept) begin
                r_wr_cnt <= w_last ? '0 : r_wr_cnt + 1'b1;
                if (w_last) begin
                    r_wr_bank <= !r_wr_bank;
                end
            end
            if (bus.req_i && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_bank   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (r_full[r_rd_bank]) r_state <= S_START;
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (bus.fft_done_i) begin
                        r_rd_bank   <= !r_rd_bank;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wr_bank, w_waddr}] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[{r_rd_bank, bus.fft_rd_addr_i}];
        end
    end

    assign bus.ready_o       = w_ready;
    assign bus.fft_start_o   = (r_state == S_START);
    assign bus.fft_bank_o    = r_rd_bank;
    assign bus.fft_rd_data_o = r_rd_data;
    assign bus.overflow_o    = r_overflow;
    assign bus.frame_cnt_o   = r_frame_cnt;
endmodule
